// File: rtl/pipe_hazard_ctrl_if.sv
// Purpose : hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// Latency : none, plain wires.
// Backpressure: stalls are expressed by the write-enable/bubble fields themselves.
// Ports   : ID operand fields, EXE/MEM/WB writeback info (datapath -> ctrl);
//           register enables, bubbles, forwarding selects, md_busy, stall_cycles (ctrl -> datapath).
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    // ID stage
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_is_muldiv;
    logic             id_branch_taken;
    // later stages
    logic             exe_rf_we;
    logic [4:0]       exe_wr_addr;
    logic             exe_is_load;
    logic             mem_rf_we;
    logic [4:0]       mem_wr_addr;
    logic             wb_rf_we;
    logic [4:0]       wb_wr_addr;
    // controls
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             iereg_we;
    logic             ie_bubble;
    logic             em_bubble;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             md_busy;
    logic [CNT_W-1:0] stall_cycles;

    // datapath side
    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_muldiv, id_branch_taken,
        output exe_rf_we, exe_wr_addr, exe_is_load, mem_rf_we, mem_wr_addr,
        output wb_rf_we, wb_wr_addr,
        input  pc_we, ifid_we, ifid_flush, iereg_we, ie_bubble, em_bubble,
        input  fwd_a_sel, fwd_b_sel, md_busy, stall_cycles
    );

    // hazard controller side
    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_muldiv, id_branch_taken,
        input  exe_rf_we, exe_wr_addr, exe_is_load, mem_rf_we, mem_wr_addr,
        input  wb_rf_we, wb_wr_addr,
        output pc_we, ifid_we, ifid_flush, iereg_we, ie_bubble, em_bubble,
        output fwd_a_sel, fwd_b_sel, md_busy, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Purpose : 5-stage pipeline hazard control: forwarding selects, load-use stall, branch flush, mul/div EXE occupancy.
// Latency : controls/forwarding are combinational; state (RUN/MD, md_cnt, stall_cycles) updates on the clock.
// Backpressure: stalls by dropping pc_we/ifid_we (1 cycle on load-use, MD_LAT-1 cycles on mul/div).
// Ports   : clk, rst_n (synchronous, active low); hz = pipe_hazard_ctrl_if.slave carrying all pipeline signals.
module pipe_hazard_ctrl #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipe_hazard_ctrl_if.slave     hz
);
    localparam int MDW = $clog2(MD_LAT) + 1;
    localparam logic [MDW-1:0] MD_INIT = MDW'(MD_LAT - 1);

    typedef enum logic {RUN, MD} state_t;

    state_t           state_q;
    logic [MDW-1:0]   md_cnt_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] stall_d;
    logic             load_use;

    // Register $0 is hardwired zero, so it never matches a producer.
    function automatic logic match(input logic [4:0] x, input logic we, input logic [4:0] addr);
        return we && (addr != 5'd0) && (addr == x);
    endfunction

    assign load_use = hz.exe_is_load &&
                      ((hz.id_uses_rs && match(hz.id_rs, hz.exe_rf_we, hz.exe_wr_addr)) ||
                       (hz.id_uses_rt && match(hz.id_rt, hz.exe_rf_we, hz.exe_wr_addr)));

    // Forwarding: EXE result only when it is not a load (load data is not ready yet).
    always_comb begin
        hz.fwd_a_sel = 2'b00;
        hz.fwd_b_sel = 2'b00;
        if (rst_n) begin
            if (hz.id_uses_rs && match(hz.id_rs, hz.exe_rf_we, hz.exe_wr_addr) && !hz.exe_is_load)
                hz.fwd_a_sel = 2'b01;
            else if (match(hz.id_rs, hz.mem_rf_we, hz.mem_wr_addr))
                hz.fwd_a_sel = 2'b10;
            else if (match(hz.id_rs, hz.wb_rf_we, hz.wb_wr_addr))
                hz.fwd_a_sel = 2'b11;

            if (hz.id_uses_rt && match(hz.id_rt, hz.exe_rf_we, hz.exe_wr_addr) && !hz.exe_is_load)
                hz.fwd_b_sel = 2'b01;
            else if (match(hz.id_rt, hz.mem_rf_we, hz.mem_wr_addr))
                hz.fwd_b_sel = 2'b10;
            else if (match(hz.id_rt, hz.wb_rf_we, hz.wb_wr_addr))
                hz.fwd_b_sel = 2'b11;
        end
    end

    // Pipeline register controls; defaults are the reset-time values.
    always_comb begin
        hz.pc_we      = 1'b0;
        hz.ifid_we    = 1'b0;
        hz.ifid_flush = 1'b1;
        hz.iereg_we   = 1'b1;
        hz.ie_bubble  = 1'b1;
        hz.em_bubble  = 1'b1;
        hz.md_busy    = 1'b0;
        if (rst_n) begin
            if (state_q == MD) begin
                // Freeze IF/ID and ID/EXE; the mul/div stays in EXE while MEM gets NOPs.
                hz.ifid_flush = 1'b0;
                hz.iereg_we   = 1'b0;
                hz.ie_bubble  = 1'b0;
                hz.md_busy    = 1'b1;
            end else if (load_use) begin
                // Stall wins over a taken branch: the branch is re-evaluated next cycle.
                hz.ifid_flush = 1'b0;
                hz.em_bubble  = 1'b0;
            end else begin
                hz.pc_we      = 1'b1;
                hz.ifid_we    = 1'b1;
                hz.ifid_flush = hz.id_branch_taken;
                hz.ie_bubble  = 1'b0;
                hz.em_bubble  = 1'b0;
            end
        end
    end

    assign stall_d         = (!hz.pc_we && (stall_q != {CNT_W{1'b1}})) ? stall_q + 1'b1 : stall_q;
    assign hz.stall_cycles = stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= RUN;
            md_cnt_q <= '0;
            stall_q  <= '0;
        end else begin
            stall_q <= stall_d;
            case (state_q)
                RUN: begin
                    // A mul/div held behind a load-use stall is accepted only once the stall clears.
                    if ((MD_LAT > 1) && hz.id_is_muldiv && !load_use) begin
                        state_q  <= MD;
                        md_cnt_q <= MD_INIT;
                    end
                end
                MD: begin
                    md_cnt_q <= md_cnt_q - MDW'(1);
                    if (md_cnt_q <= MDW'(1))
                        state_q <= RUN;
                end
                default: state_q <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   exp_stall = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) hz();

    pipe_hazard_ctrl #(.MD_LAT(4), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    // {pc_we, ifid_we, ifid_flush, iereg_we, ie_bubble, em_bubble, md_busy}
    wire [6:0] ctl = {hz.pc_we, hz.ifid_we, hz.ifid_flush, hz.iereg_we,
                      hz.ie_bubble, hz.em_bubble, hz.md_busy};
    localparam logic [6:0] C_RST = 7'b0011110;
    localparam logic [6:0] C_RUN = 7'b1101000;
    localparam logic [6:0] C_BR  = 7'b1111000;
    localparam logic [6:0] C_LU  = 7'b0001100;
    localparam logic [6:0] C_MD  = 7'b0000011;

    task automatic clear_inputs();
        hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_uses_rs = 1'b0; hz.id_uses_rt = 1'b0;
        hz.id_is_muldiv = 1'b0; hz.id_branch_taken = 1'b0;
        hz.exe_rf_we = 1'b0; hz.exe_wr_addr = 5'd0; hz.exe_is_load = 1'b0;
        hz.mem_rf_we = 1'b0; hz.mem_wr_addr = 5'd0;
        hz.wb_rf_we = 1'b0; hz.wb_wr_addr = 5'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        // A matching EXE producer must not leak through during reset.
        hz.exe_rf_we = 1'b1; hz.exe_wr_addr = 5'd5; hz.id_rs = 5'd5; hz.id_uses_rs = 1'b1;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({ctl, hz.fwd_a_sel, hz.fwd_b_sel} !== {C_RST, 4'b0000}) begin
                errors++;
                $display("FAIL reset_ctl cyc%0d: got %b want %b", i, {ctl, hz.fwd_a_sel, hz.fwd_b_sel}, {C_RST, 4'b0000});
            end
        end
        clear_inputs();
        rst_n = 1'b1;
        #1;
        checks++;
        if (ctl !== C_RUN) begin
            errors++; $display("FAIL release_ctl: got %b want %b", ctl, C_RUN);
        end
        step();
        checks++;
        if (hz.stall_cycles !== 4'd0 || hz.pc_we !== 1'b1) begin
            errors++; $display("FAIL release_stall: got cnt=%0d pc_we=%b want 0/1", hz.stall_cycles, hz.pc_we);
        end
    endtask

    task automatic test_alu_raw();
        clear_inputs();
        hz.exe_rf_we = 1'b1; hz.exe_wr_addr = 5'd5; hz.id_rs = 5'd5; hz.id_uses_rs = 1'b1;
        hz.id_rt = 5'd5; hz.id_uses_rt = 1'b1;
        #1;
        checks++;
        if ({hz.fwd_a_sel, hz.fwd_b_sel, ctl} !== {2'b01, 2'b01, C_RUN}) begin
            errors++; $display("FAIL alu_raw: got %b want %b", {hz.fwd_a_sel, hz.fwd_b_sel, ctl}, {2'b01, 2'b01, C_RUN});
        end
        hz.id_uses_rt = 1'b0;
        #1;
        checks++;
        if (hz.fwd_b_sel !== 2'b00) begin
            errors++; $display("FAIL alu_raw_unused_rt: got %b want 00", hz.fwd_b_sel);
        end
        hz.exe_wr_addr = 5'd0; hz.id_rs = 5'd0;
        #1;
        checks++;
        if (hz.fwd_a_sel !== 2'b00) begin
            errors++; $display("FAIL alu_raw_r0: got %b want 00", hz.fwd_a_sel);
        end
        step();
    endtask

    task automatic test_load_use();
        clear_inputs();
        hz.exe_is_load = 1'b1; hz.exe_rf_we = 1'b1; hz.exe_wr_addr = 5'd8;
        hz.id_rt = 5'd8; hz.id_uses_rt = 1'b1;
        #1;
        checks++;
        if ({ctl, hz.fwd_b_sel} !== {C_LU, 2'b00}) begin
            errors++; $display("FAIL load_use_stall: got %b want %b", {ctl, hz.fwd_b_sel}, {C_LU, 2'b00});
        end
        step();
        exp_stall++;
        // load has moved to MEM, EXE holds the bubble
        hz.exe_is_load = 1'b0; hz.exe_rf_we = 1'b0; hz.exe_wr_addr = 5'd0;
        hz.mem_rf_we = 1'b1; hz.mem_wr_addr = 5'd8;
        #1;
        checks++;
        if ({hz.fwd_b_sel, hz.pc_we, hz.stall_cycles} !== {2'b10, 1'b1, 4'(exp_stall)}) begin
            errors++; $display("FAIL load_use_after: got fwd=%b pc_we=%b cnt=%0d want 10/1/%0d",
                               hz.fwd_b_sel, hz.pc_we, hz.stall_cycles, exp_stall);
        end
        step();
    endtask

    task automatic test_priority();
        clear_inputs();
        hz.id_rs = 5'd3; hz.id_uses_rs = 1'b1;
        hz.exe_rf_we = 1'b1; hz.exe_wr_addr = 5'd3;
        hz.mem_rf_we = 1'b1; hz.mem_wr_addr = 5'd3;
        hz.wb_rf_we = 1'b1;  hz.wb_wr_addr = 5'd3;
        #1; checks++;
        if (hz.fwd_a_sel !== 2'b01) begin errors++; $display("FAIL prio_exe: got %b want 01", hz.fwd_a_sel); end
        hz.exe_rf_we = 1'b0;
        #1; checks++;
        if (hz.fwd_a_sel !== 2'b10) begin errors++; $display("FAIL prio_mem: got %b want 10", hz.fwd_a_sel); end
        hz.mem_rf_we = 1'b0;
        #1; checks++;
        if (hz.fwd_a_sel !== 2'b11) begin errors++; $display("FAIL prio_wb: got %b want 11", hz.fwd_a_sel); end
        hz.wb_rf_we = 1'b0;
        #1; checks++;
        if (hz.fwd_a_sel !== 2'b00) begin errors++; $display("FAIL prio_none: got %b want 00", hz.fwd_a_sel); end
        // $0 everywhere, even a load, must neither forward nor stall
        hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_uses_rt = 1'b1;
        hz.exe_rf_we = 1'b1; hz.exe_is_load = 1'b1; hz.exe_wr_addr = 5'd0;
        hz.mem_rf_we = 1'b1; hz.mem_wr_addr = 5'd0; hz.wb_rf_we = 1'b1; hz.wb_wr_addr = 5'd0;
        #1; checks++;
        if ({hz.fwd_a_sel, hz.fwd_b_sel, ctl} !== {4'b0000, C_RUN}) begin
            errors++; $display("FAIL prio_r0: got %b want %b", {hz.fwd_a_sel, hz.fwd_b_sel, ctl}, {4'b0000, C_RUN});
        end
        step();
    endtask

    task automatic test_muldiv();
        clear_inputs();
        hz.id_is_muldiv = 1'b1;
        #1; checks++;
        if (ctl !== C_RUN) begin errors++; $display("FAIL md_accept: got %b want %b", ctl, C_RUN); end
        step();
        // Next ID instr: a taken branch reading r5 from WB; ignored while MD
        hz.id_is_muldiv = 1'b0; hz.id_branch_taken = 1'b1;
        hz.id_rs = 5'd5; hz.id_uses_rs = 1'b1; hz.wb_rf_we = 1'b1; hz.wb_wr_addr = 5'd5;
        for (int i = 0; i < 3; i++) begin
            #1; checks++;
            if ({ctl, hz.fwd_a_sel} !== {C_MD, 2'b11}) begin
                errors++; $display("FAIL md_busy cyc%0d: got %b want %b", i, {ctl, hz.fwd_a_sel}, {C_MD, 2'b11});
            end
            step();
            exp_stall++;
        end
        #1; checks++;
        if ({ctl, hz.stall_cycles} !== {C_BR, 4'(exp_stall)}) begin
            errors++; $display("FAIL md_done: got ctl=%b cnt=%0d want ctl=%b cnt=%0d", ctl, hz.stall_cycles, C_BR, exp_stall);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_muldiv_load_use_reset();
        clear_inputs();
        hz.exe_is_load = 1'b1; hz.exe_rf_we = 1'b1; hz.exe_wr_addr = 5'd7;
        hz.id_rs = 5'd7; hz.id_uses_rs = 1'b1; hz.id_is_muldiv = 1'b1;
        #1; checks++;
        if (ctl !== C_LU) begin errors++; $display("FAIL mdlu_stall: got %b want %b", ctl, C_LU); end
        step();
        exp_stall++;
        hz.exe_is_load = 1'b0; hz.exe_rf_we = 1'b0; hz.exe_wr_addr = 5'd0;
        hz.mem_rf_we = 1'b1; hz.mem_wr_addr = 5'd7;
        #1; checks++;
        if (ctl !== C_RUN) begin errors++; $display("FAIL mdlu_not_taken: got %b want %b", ctl, C_RUN); end
        step();  // edge t: mul/div accepted
        hz.id_is_muldiv = 1'b0;
        #1; checks++;
        if (ctl !== C_MD) begin errors++; $display("FAIL mdlu_accepted: got %b want %b", ctl, C_MD); end
        step();  // t+1
        rst_n = 1'b0;
        #1; checks++;
        if (ctl !== C_RST) begin errors++; $display("FAIL md_abort_rst: got %b want %b", ctl, C_RST); end
        step();  // t+2 reset edge
        rst_n = 1'b1;
        exp_stall = 0;
        clear_inputs();
        #1; checks++;
        if ({ctl, hz.stall_cycles} !== {C_RUN, 4'd0}) begin
            errors++; $display("FAIL md_abort_after: got ctl=%b cnt=%0d want ctl=%b cnt=0", ctl, hz.stall_cycles, C_RUN);
        end
        step();
        checks++;
        if (hz.md_busy !== 1'b0 || hz.pc_we !== 1'b1) begin
            errors++; $display("FAIL md_abort_residual: got md_busy=%b pc_we=%b want 0/1", hz.md_busy, hz.pc_we);
        end
    endtask

    task automatic test_branch_load_use();
        clear_inputs();
        hz.exe_is_load = 1'b1; hz.exe_rf_we = 1'b1; hz.exe_wr_addr = 5'd9;
        hz.id_rs = 5'd9; hz.id_uses_rs = 1'b1; hz.id_branch_taken = 1'b1;
        #1; checks++;
        if (ctl !== C_LU) begin errors++; $display("FAIL br_lu_stall: got %b want %b", ctl, C_LU); end
        step();
        exp_stall++;
        hz.exe_is_load = 1'b0; hz.exe_rf_we = 1'b0; hz.exe_wr_addr = 5'd0;
        hz.mem_rf_we = 1'b1; hz.mem_wr_addr = 5'd9;
        #1; checks++;
        if ({ctl, hz.fwd_a_sel, hz.stall_cycles} !== {C_BR, 2'b10, 4'(exp_stall)}) begin
            errors++; $display("FAIL br_lu_flush: got %b want %b", {ctl, hz.fwd_a_sel, hz.stall_cycles},
                               {C_BR, 2'b10, 4'(exp_stall)});
        end
        clear_inputs();
        step();
    endtask

    task automatic test_saturation();
        clear_inputs();
        hz.exe_is_load = 1'b1; hz.exe_rf_we = 1'b1; hz.exe_wr_addr = 5'd4;
        hz.id_rt = 5'd4; hz.id_uses_rt = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (exp_stall < 15) exp_stall++;
            checks++;
            if (hz.stall_cycles !== 4'(exp_stall)) begin
                errors++; $display("FAIL stall_sat cyc%0d: got %0d want %0d", i, hz.stall_cycles, exp_stall);
            end
        end
        clear_inputs();
        step();
        checks++;
        if (hz.stall_cycles !== 4'd15) begin
            errors++; $display("FAIL stall_sat_hold: got %0d want 15", hz.stall_cycles);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_alu_raw();
        test_load_use();
        test_priority();
        test_muldiv();
        test_muldiv_load_use_reset();
        test_branch_load_use();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
